fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one synchronous FIFO (fifo_syn: wr, data, full, usedw) among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to MAX_BURST words and drives registered FIFO write strobes.
- It never overflows the FIFO, including the write already in flight.

Parameters:
- WIDTH, 8, data word width; matches FIFO data/q width.
- DEPTH, 8, FIFO depth in words; power of two.
- AW, 3, FIFO usedw width (log2 DEPTH); usedw wraps to 0 when full.
- NUM_REQ, 4, number of producers; 2..8.
- MAX_BURST, 4, maximum words per grant; 1..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-producer word valid.
- req_data  in  NUM_REQ*WIDTH  flattened producer data; producer i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-producer accept; combinational from registered state and FIFO status.
- fifo_full  in  1  FIFO full flag.
- fifo_usedw  in  AW  FIFO occupancy.
- fifo_wr  out  1  registered FIFO write strobe.
- fifo_data  out  WIDTH  registered FIFO write data.
- grant_id  out  3  index of current grantee; valid while busy=1.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0, busy=0, fifo_wr=0, fifo_data=0, req_ready=0.
- space = !fifo_full && !(fifo_wr && fifo_usedw==DEPTH-1).
  - This accounts for the registered write that lands on the next edge.
  - FIFO reads only free space, so the check is conservative.
- IDLE:
  - If any req_valid: grant the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Load grant_id, clear burst_cnt, go to GRANT.
  - If none valid: stay in IDLE.
  - req_ready is all zero in IDLE.
- GRANT:
  - req_ready[grant_id] = space; all other bits 0.
  - Transfer when req_valid[grant_id] && req_ready[grant_id]. On the next edge: fifo_wr=1, fifo_data=req_data[grant_id], burst_cnt+1.
  - Otherwise fifo_wr=0 next cycle and fifo_data holds its value.
  - Latency: exactly 1 cycle from handshake to fifo_wr.
- Release: return to IDLE and set rr_ptr = (grant_id+1) mod NUM_REQ when either:
  - a transfer occurs with burst_cnt==MAX_BURST-1, or
  - req_valid[grant_id]==0 in any GRANT cycle.
- One mandatory idle (arbitration) cycle follows every release. Max throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Backpressure (space=0) with valid high:
  - Stay in GRANT; no transfer, no burst count, no release.
  - The grant is held until space returns.
- Producer data must be stable while valid is high and ready is low; data is sampled only on the transfer cycle.
- Non-granted producers' valid is ignored in GRANT.
- rr_ptr and burst_cnt wrap modulo NUM_REQ and MAX_BURST respectively.
- Reset mid-burst:
  - All state clears asynchronously and any pending fifo_wr is dropped.
  - After deassertion, arbitration restarts from index 0.
- Invariant: fifo_wr never asserts while fifo_full=1.

Test Plan:
- All 4 producers valid continuously; FIFO drained every cycle; data = 8'h{id,count}.
  - Required: grant order 0,1,2,3,0.
  - Each grant writes exactly 4 words, with one fifo_wr-low cycle between bursts.
  - fifo_data sequence 00,01,02,03,10,11,...
- Only producer 2 valid for 3 words (8'hab,8'h12,8'h34), then drops.
  - Required: 3 fifo_wr pulses, 1 cycle after each handshake, in order.
  - Release on valid low; rr_ptr=3; busy=0 on the next cycle.
- Overflow guard: MAX_BURST=16, producer 0 streams 10 words, no FIFO reads.
  - Required: exactly 8 fifo_wr pulses.
  - req_ready[0] falls in the cycle where fifo_usedw==7 and fifo_wr=1.
  - fifo_wr is never high with fifo_full.
  - After 2 reads: words 9 and 10 are written and the grant remains held until release.
- Priority rotation: rr_ptr=1 after producer 0 releases; producers 0 and 3 valid.
  - Required: producer 3 granted (grant_id=3), then producer 0.
- Reset mid-burst: assert rst during the 2nd word of a burst.
  - Required: fifo_wr, busy and req_ready go 0 immediately (before the next edge).
  - After release, first grant goes to the lowest-index valid producer.
- Single request, FIFO full at grant:
  - Required: grant is held with req_ready=0 and no writes.
  - One FIFO read → req_ready=1 next cycle, one write, no overflow.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ valid/ready producers share the write port of one
// synchronous FIFO. It grants one producer at a time for bursts of up to MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    input  logic [AW-1:0]            fifo_usedw,
    output logic                     fifo_wr,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [2:0]               grant_id,
    output logic                     busy
);

    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [2:0]       rr_ptr, rr_ptr_nxt;
    logic [2:0]       grant_id_nxt;
    logic [BW-1:0]    burst_cnt, burst_cnt_nxt;
    logic             fifo_wr_nxt;
    logic [WIDTH-1:0] fifo_data_nxt;

    logic             space;
    logic             gnt_valid;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;
    logic             last;
    logic             found;
    logic [2:0]       pick;
    logic [3:0]       cand;

    // A write already registered lands on the next edge, so usedw==DEPTH-1 plus fifo_wr means full.
    assign space = !fifo_full && !(fifo_wr && (fifo_usedw == AW'(DEPTH - 1)));
    assign xfer  = (state == GRANT) && gnt_valid && space;
    assign last  = (burst_cnt == BW'(MAX_BURST - 1));

    // Grantee's valid/data and ready fan-out
    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == 3'(j)) begin
                gnt_valid = req_valid[j];
                gnt_data  = req_data[j*WIDTH +: WIDTH];
                if (state == GRANT) begin
                    req_ready[j] = space;
                end
            end
        end
    end

    // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        cand  = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 4'(rr_ptr) + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (cand == 4'(j)) && req_valid[j]) begin
                    found = 1'b1;
                    pick  = 3'(j);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 3'd0;
            burst_cnt <= '0;
            grant_id  <= 3'd0;
            busy      <= 1'b0;
            fifo_wr   <= 1'b0;
            fifo_data <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            grant_id  <= grant_id_nxt;
            busy      <= (state_nxt == GRANT);
            fifo_wr   <= fifo_wr_nxt;
            fifo_data <= fifo_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        grant_id_nxt  = grant_id;
        fifo_wr_nxt   = 1'b0;
        fifo_data_nxt = fifo_data;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_id_nxt  = pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    fifo_wr_nxt   = 1'b1;
                    fifo_data_nxt = gnt_data;
                    burst_cnt_nxt = last ? '0 : burst_cnt + BW'(1);
                end
                // Release on a completed burst or when the grantee withdraws valid
                if (!gnt_valid || (xfer && last)) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-producer word queues, a behavioural FIFO model and a
// write-side scoreboard that checks data order and one-cycle handshake-to-write latency.
module tb_fifo_wr_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned NR    = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [31:0]      cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NR-1:0]       req_valid = '0;
    logic [NR*WIDTH-1:0] req_data  = '0;
    logic [NR-1:0]       req_ready;
    logic                fifo_full;
    logic [AW-1:0]       fifo_usedw;
    logic                fifo_wr;
    logic [WIDTH-1:0]    fifo_data;
    logic [2:0]          grant_id;
    logic                busy;
    logic                fifo_rd = 1'b0;
    int                  fcount;

    logic [NR-1:0]       v16 = '0;
    logic [NR*WIDTH-1:0] d16 = '0;
    logic [NR-1:0]       r16;
    logic                full16;
    logic [AW-1:0]       usedw16;
    logic                wr16;
    logic [WIDTH-1:0]    data16;
    logic [2:0]          gid16;
    logic                busy16;
    logic                rd16 = 1'b0;
    int                  fcount16;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cyc = '0;

    logic [WIDTH-1:0] src [NR][$];
    logic [WIDTH-1:0] src16 [$];
    sb_t sb [$];
    sb_t sb16 [$];
    logic [2:0] grants [$];
    int grants16;

    logic             obs_wr, obs_busy, obs16_wr, obs16_busy, prev_busy, prev_busy16;
    logic [WIDTH-1:0] obs_data;
    logic [2:0]       obs_gid;
    logic [NR-1:0]    obs_ready, obs_hs, obs16_ready, obs16_hs;
    logic [AW-1:0]    obs16_usedw;
    int               wr_total, wr16_total;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_usedw(fifo_usedw), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .grant_id(grant_id), .busy(busy)
    );

    fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NUM_REQ(NR), .MAX_BURST(16)) dut16 (
        .clk(clk), .rst(rst), .req_valid(v16), .req_data(d16), .req_ready(r16),
        .fifo_full(full16), .fifo_usedw(usedw16), .fifo_wr(wr16), .fifo_data(data16),
        .grant_id(gid16), .busy(busy16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Behavioural FIFO occupancy; usedw wraps to 0 when full
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcount   <= 0;
            fcount16 <= 0;
        end else begin
            fcount   <= fcount + (fifo_wr ? 1 : 0) - ((fifo_rd && fcount > 0) ? 1 : 0);
            fcount16 <= fcount16 + (wr16 ? 1 : 0) - ((rd16 && fcount16 > 0) ? 1 : 0);
        end
    end
    assign fifo_full  = (fcount >= DEPTH);
    assign fifo_usedw = AW'(fcount);
    assign full16     = (fcount16 >= DEPTH);
    assign usedw16    = AW'(fcount16);

    // Scoreboard: pop on each FIFO write, push on each handshake
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            sb.delete();
            sb16.delete();
        end else begin
            if (fifo_wr) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_data: write of %h at cycle %0d, required no write", fifo_data, cyc);
                end else begin
                    e = sb.pop_front();
                    if (fifo_data !== e.data || cyc != e.cyc + 32'd1) begin
                        n_bad++;
                        $display("FAIL sb_data: got %h at cycle %0d, required %h at cycle %0d", fifo_data, cyc, e.data, e.cyc + 32'd1);
                    end
                end
                n_cmp++;
                if (fifo_full !== 1'b0) begin
                    n_bad++;
                    $display("FAIL overflow: fifo_wr=1 with fifo_full=%b, required fifo_full=0", fifo_full);
                end
            end
            if (wr16) begin
                n_cmp++;
                if (sb16.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb16_data: write of %h at cycle %0d, required no write", data16, cyc);
                end else begin
                    e = sb16.pop_front();
                    if (data16 !== e.data || cyc != e.cyc + 32'd1) begin
                        n_bad++;
                        $display("FAIL sb16_data: got %h at cycle %0d, required %h at cycle %0d", data16, cyc, e.data, e.cyc + 32'd1);
                    end
                end
                n_cmp++;
                if (full16 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL overflow16: fifo_wr=1 with fifo_full=%b, required fifo_full=0", full16);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) sb.push_back('{data: req_data[i*WIDTH +: WIDTH], cyc: cyc});
            end
            if (v16[0] && r16[0]) sb16.push_back('{data: d16[WIDTH-1:0], cyc: cyc});
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (src[i].size() != 0);
            req_data[i*WIDTH +: WIDTH] = (src[i].size() != 0) ? src[i][0] : '0;
        end
        v16[0] = (src16.size() != 0);
        d16[WIDTH-1:0] = (src16.size() != 0) ? src16[0] : '0;
    endtask

    // Observe one cycle at the falling edge, then advance sources just after the rising edge
    task automatic tick();
        @(negedge clk);
        obs_wr = fifo_wr; obs_data = fifo_data; obs_busy = busy; obs_gid = grant_id;
        obs_ready = req_ready; obs_hs = req_valid & req_ready;
        obs16_wr = wr16; obs16_busy = busy16; obs16_ready = r16; obs16_usedw = usedw16;
        obs16_hs = v16 & r16;
        if (obs_busy && !prev_busy) grants.push_back(obs_gid);
        if (obs16_busy && !prev_busy16) grants16++;
        prev_busy = obs_busy; prev_busy16 = obs16_busy;
        if (obs_wr) wr_total++;
        if (obs16_wr) wr16_total++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (obs_hs[i]) void'(src[i].pop_front());
        if (obs16_hs[0]) void'(src16.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) src[i].delete();
        src16.delete();
        fifo_rd = 1'b0; rd16 = 1'b0;
        drive();
        grants.delete(); grants16 = 0; wr_total = 0; wr16_total = 0;
        obs_wr = 1'b0; obs_busy = 1'b0; obs16_wr = 1'b0; obs16_busy = 1'b0;
        prev_busy = 1'b0; prev_busy16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src[0].push_back(8'h5a);
        drive();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({fifo_wr, busy, req_ready, grant_id, fifo_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: wr=%b busy=%b ready=%b gid=%0d data=%h, required all 0", fifo_wr, busy, req_ready, grant_id, fifo_data);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [19:0] pat;
        logic [WIDTH-1:0] dq [$];
        logic [WIDTH-1:0] exp_d;
        do_reset();
        for (int i = 0; i < NR; i++) for (int c = 0; c < 8; c++) src[i].push_back(8'(i * 16 + c));
        fifo_rd = 1'b1;
        drive();
        for (int b = 0; b < 20 && !obs_wr; b++) tick();
        for (int j = 0; j < 20; j++) begin
            pat[j] = obs_wr;
            if (obs_wr) dq.push_back(obs_data);
            tick();
        end
        n_cmp++;
        if (pat !== 20'b01111011110111101111) begin
            n_bad++;
            $display("FAIL rr_wr_pattern: got %b, required %b", pat, 20'b01111011110111101111);
        end
        for (int k = 0; k < 16; k++) begin
            exp_d = 8'((k / 4) * 16 + (k % 4));
            n_cmp++;
            if (k >= dq.size() || dq[k] !== exp_d) begin
                n_bad++;
                $display("FAIL rr_data[%0d]: got %h, required %h", k, (k < dq.size()) ? dq[k] : 8'hxx, exp_d);
            end
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (k >= grants.size() || grants[k] !== 3'(k % 4)) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got %0d, required %0d", k, (k < grants.size()) ? grants[k] : 3'bx, k % 4);
            end
        end
        for (int i = 0; i < NR; i++) src[i].delete();
        drive();
        repeat (4) tick();
    endtask

    task automatic test_single_drop();
        do_reset();
        src[2].push_back(8'hab); src[2].push_back(8'h12); src[2].push_back(8'h34);
        fifo_rd = 1'b1;
        drive();
        for (int b = 0; b < 20 && wr_total < 3; b++) tick();
        tick();
        n_cmp++;
        if (wr_total != 3 || obs_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_release: writes=%0d busy=%b, required writes=3 busy=0", wr_total, obs_busy);
        end
        n_cmp++;
        if (grants.size() != 1 || grants[0] !== 3'd2) begin
            n_bad++;
            $display("FAIL drop_grant: got %0d grants first=%0d, required 1 grant to 2", grants.size(), grants[0]);
        end
        // Pointer now at 3: with producers 0,1,3 valid the order is 3,0,1
        src[0].push_back(8'h01); src[1].push_back(8'h02); src[3].push_back(8'h03);
        drive();
        for (int b = 0; b < 40 && !(grants.size() >= 4 && !obs_busy); b++) tick();
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (k >= grants.size() || grants[k] !== 3'((k + 2) % 4)) begin
                n_bad++;
                $display("FAIL drop_next_grant[%0d]: got %0d, required %0d", k, (k < grants.size()) ? grants[k] : 3'bx, (k + 2) % 4);
            end
        end
    endtask

    task automatic test_overflow();
        int seen = 0;
        do_reset();
        for (int k = 0; k < 10; k++) src16.push_back(8'(8'h40 + k));
        drive();
        for (int b = 0; b < 30; b++) begin
            tick();
            if (obs16_wr && obs16_usedw == 3'd7) begin
                seen++;
                n_cmp++;
                if (obs16_ready[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_ready_fall: req_ready[0]=%b with usedw=7 and wr=1, required 0", obs16_ready[0]);
                end
            end
        end
        n_cmp++;
        if (wr16_total != 8 || obs16_busy !== 1'b1 || seen != 1) begin
            n_bad++;
            $display("FAIL ovf_stall: writes=%0d busy=%b usedw7_wr_cycles=%0d, required 8, 1, 1", wr16_total, obs16_busy, seen);
        end
        rd16 = 1'b1;
        tick(); tick();
        rd16 = 1'b0;
        for (int b = 0; b < 20 && obs16_busy; b++) tick();
        n_cmp++;
        if (wr16_total != 10 || grants16 != 1 || obs16_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_resume: writes=%0d grants=%0d busy=%b, required 10, 1, 0", wr16_total, grants16, obs16_busy);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        src[0].push_back(8'h55);
        fifo_rd = 1'b1;
        drive();
        for (int b = 0; b < 20 && !(grants.size() >= 1 && !obs_busy); b++) tick();
        src[0].push_back(8'h66); src[3].push_back(8'h77);
        drive();
        for (int b = 0; b < 30 && !(grants.size() >= 3 && !obs_busy); b++) tick();
        n_cmp++;
        if (grants.size() < 3 || grants[1] !== 3'd3 || grants[2] !== 3'd0) begin
            n_bad++;
            $display("FAIL rotation: got %0d grants (2nd=%0d 3rd=%0d), required 2nd=3 3rd=0", grants.size(), grants[1], grants[2]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int hs_n = 0;
        do_reset();
        fifo_rd = 1'b1;
        src[2].push_back(8'h01);
        drive();
        for (int b = 0; b < 20 && !(grants.size() >= 1 && !obs_busy); b++) tick();
        for (int k = 0; k < 4; k++) src[1].push_back(8'(8'ha0 + k));
        drive();
        for (int b = 0; b < 20 && hs_n < 2; b++) begin
            tick();
            if (obs_hs[1]) hs_n++;
        end
        n_cmp++;
        if (fifo_wr !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_burst_pre: wr=%b busy=%b, required 1 1", fifo_wr, busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (fifo_wr !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL mid_burst_async: wr=%b busy=%b ready=%b, required 0 0 0", fifo_wr, busy, req_ready);
        end
        for (int i = 0; i < NR; i++) src[i].delete();
        src[2].push_back(8'hb0); src[3].push_back(8'hc0);
        drive();
        grants.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int b = 0; b < 30 && !(grants.size() >= 2 && !obs_busy); b++) tick();
        n_cmp++;
        if (grants.size() < 2 || grants[0] !== 3'd2 || grants[1] !== 3'd3) begin
            n_bad++;
            $display("FAIL mid_burst_restart: got %0d grants (%0d,%0d), required 2 then 3", grants.size(), grants[0], grants[1]);
        end
    endtask

    task automatic test_full_at_grant();
        logic any_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) src[0].push_back(8'(8'h80 + k));
        drive();
        for (int b = 0; b < 40 && !(src[0].size() == 0 && !obs_busy); b++) tick();
        n_cmp++;
        if (wr_total != 8) begin
            n_bad++;
            $display("FAIL full_fill: writes=%0d, required 8", wr_total);
        end
        src[1].push_back(8'hc5);
        drive();
        for (int j = 0; j < 6; j++) begin
            tick();
            if (obs_ready != '0) any_ready = 1'b1;
        end
        n_cmp++;
        if (obs_busy !== 1'b1 || obs_gid !== 3'd1 || any_ready || wr_total != 8) begin
            n_bad++;
            $display("FAIL full_hold: busy=%b gid=%0d ready_seen=%b writes=%0d, required 1 1 0 8", obs_busy, obs_gid, any_ready, wr_total);
        end
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        tick();
        n_cmp++;
        if (obs_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL full_ready_return: ready=%b, required 0010", obs_ready);
        end
        for (int b = 0; b < 10 && obs_busy; b++) tick();
        tick();
        n_cmp++;
        if (wr_total != 9 || fcount != 8) begin
            n_bad++;
            $display("FAIL full_one_write: writes=%0d occupancy=%0d, required 9 8", wr_total, fcount);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_drop();
        test_overflow();
        test_rotation();
        test_reset_mid_burst();
        test_full_at_grant();
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0 || sb16.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: pending %0d/%0d, required 0/0", sb.size(), sb16.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
